// File: rtl/nist_health_monitor.sv
// rtl/nist_health_monitor.sv - windowed failure-event health monitor for NIST test stages
module nist_health_monitor #(
  parameter int WIN_LOG    = 10,
  parameter int FAIL_TH    = 2,
  parameter int WARMUP_WIN = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] err_in,
  input  logic [3:0] test_mask,
  input  logic       clr_alarm,
  output logic [3:0] fail_flags,
  output logic       warn,
  output logic       alarm,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_WARMUP  = 2'b00,
    ST_MONITOR = 2'b01,
    ST_WARN    = 2'b10,
    ST_ALARM   = 2'b11
  } state_e;

  localparam logic [3:0] FAIL_TH_L   = 4'(FAIL_TH);
  localparam logic [1:0] WARMUP_LAST = 2'(WARMUP_WIN - 1);

  state_e             state_q, state_d;
  logic [WIN_LOG-1:0] win_cnt_q;
  logic [3:0]         total_q, total_d;
  logic [1:0]         wu_cnt_q, wu_cnt_d;
  logic [3:0]         flags_q, flags_d;
  logic [3:0]         err_q;

  logic [3:0] ev;
  logic [2:0] ev_cnt;
  logic [4:0] sum_raw;
  logic [3:0] sum_sat;
  logic       win_end;
  logic       bad;

  // Rising-edge events gated by the current mask; history is kept unmasked
  assign ev      = err_in & ~err_q & test_mask;
  assign ev_cnt  = {2'b00, ev[0]} + {2'b00, ev[1]} + {2'b00, ev[2]} + {2'b00, ev[3]};
  assign sum_raw = {1'b0, total_q} + {2'b00, ev_cnt};
  assign sum_sat = (sum_raw > 5'd15) ? 4'd15 : sum_raw[3:0];
  assign win_end = &win_cnt_q;
  assign bad     = (sum_sat >= FAIL_TH_L);

  // Free-running window counter and err_in history
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_cnt_q <= '0;
      err_q     <= '0;
    end else begin
      win_cnt_q <= win_cnt_q + WIN_LOG'(1);
      err_q     <= err_in;
    end
  end

  // State, window total, warmup count and sticky flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_WARMUP;
      total_q  <= '0;
      wu_cnt_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      wu_cnt_q <= wu_cnt_d;
      flags_q  <= flags_d;
    end
  end

  // Next-state logic: window evaluation, ALARM stickiness and clear handling
  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    wu_cnt_d = wu_cnt_q;
    unique case (state_q)
      ST_WARMUP: begin
        total_d = '0;
        if (win_end) begin
          wu_cnt_d = wu_cnt_q + 2'd1;
          if (wu_cnt_q == WARMUP_LAST) state_d = ST_MONITOR;
        end
      end
      ST_MONITOR: begin
        if (win_end) begin
          total_d = '0;
          if (bad) state_d = ST_WARN;
        end else begin
          total_d = sum_sat;
        end
      end
      ST_WARN: begin
        if (win_end) begin
          total_d = '0;
          state_d = bad ? ST_ALARM : ST_MONITOR;
        end else begin
          total_d = sum_sat;
        end
      end
      ST_ALARM: begin
        if (clr_alarm) begin
          state_d = ST_MONITOR;
          total_d = '0;
        end else if (win_end) begin
          total_d = '0;
        end else begin
          total_d = sum_sat;
        end
      end
    endcase
  end

  // Sticky per-test flags; a clear beats a coincident event
  always_comb begin
    flags_d = flags_q;
    if (clr_alarm) begin
      flags_d = '0;
    end else if (state_q != ST_WARMUP) begin
      flags_d = flags_q | ev;
    end
  end

  assign state      = state_q;
  assign warn       = (state_q == ST_WARN);
  assign alarm      = (state_q == ST_ALARM);
  assign fail_flags = flags_q;

endmodule

// File: tb/tb_nist_health_monitor.sv
// tb/tb_nist_health_monitor.sv - window-level vector table with scoreboard for nist_health_monitor
module tb_nist_health_monitor;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [3:0] err_in = 4'h0;
  logic [3:0] test_mask = 4'hF;
  logic       clr_alarm = 1'b0;
  logic [3:0] fail_flags;
  logic       warn;
  logic       alarm;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  nist_health_monitor dut (
    .clk        (clk),
    .rstn       (rstn),
    .err_in     (err_in),
    .test_mask  (test_mask),
    .clr_alarm  (clr_alarm),
    .fail_flags (fail_flags),
    .warn       (warn),
    .alarm      (alarm),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] mask;
    logic [3:0] pulse;
    logic [3:0] hold;
    int         clr_at;
    logic [1:0] exp_state;
    logic [3:0] exp_flags;
  } vec_t;

  typedef struct {
    logic [1:0] st;
    logic [3:0] fl;
    int         idx;
  } exp_t;

  vec_t tbl[23];
  exp_t sb_q[$];

  function automatic vec_t mk(logic rst, logic [3:0] mask, logic [3:0] pulse, logic [3:0] hold,
                              int clr_at, logic [1:0] st, logic [3:0] fl);
    vec_t v;
    v.rst = rst; v.mask = mask; v.pulse = pulse; v.hold = hold;
    v.clr_at = clr_at; v.exp_state = st; v.exp_flags = fl;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] e, input logic [3:0] m, input logic c);
    err_in = e; test_mask = m; clr_alarm = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    err_in = 4'h0; test_mask = 4'hF; clr_alarm = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_state", -1, {2'b00, state}, 4'h0);
    chk("rst_flags", -1, fail_flags, 4'h0);
    chk("rst_warn", -1, {3'b000, warn}, 4'h0);
    chk("rst_alarm", -1, {3'b000, alarm}, 4'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    logic [1:0] prev;
    logic [1:0] mid;
    logic [3:0] e;
    exp_t       x;

    tbl[0]  = mk(1, 4'hF, 4'b0001, 4'h0,   -1, 2'b01, 4'b0000);
    tbl[1]  = mk(0, 4'hF, 4'b1000, 4'h0,   -1, 2'b01, 4'b1000);
    tbl[2]  = mk(0, 4'hF, 4'b1000, 4'h0,   -1, 2'b01, 4'b1000);
    tbl[3]  = mk(0, 4'hF, 4'b0101, 4'h0,   -1, 2'b10, 4'b1101);
    tbl[4]  = mk(0, 4'hF, 4'b0101, 4'h0,   -1, 2'b11, 4'b1101);
    tbl[5]  = mk(0, 4'hF, 4'b0000, 4'h0,   -1, 2'b11, 4'b1101);
    tbl[6]  = mk(0, 4'hF, 4'b0000, 4'h0,   -1, 2'b11, 4'b1101);
    tbl[7]  = mk(0, 4'hF, 4'b0000, 4'h0,   -1, 2'b11, 4'b1101);
    tbl[8]  = mk(0, 4'hF, 4'b0000, 4'h0,   -1, 2'b11, 4'b1101);
    tbl[9]  = mk(0, 4'hF, 4'b0000, 4'h0,   -1, 2'b11, 4'b1101);
    tbl[10] = mk(0, 4'hF, 4'b0000, 4'h0, 1023, 2'b01, 4'b0000);
    tbl[11] = mk(0, 4'hF, 4'b0000, 4'h0,   -1, 2'b01, 4'b0000);
    tbl[12] = mk(0, 4'hF, 4'b0011, 4'h0,   -1, 2'b10, 4'b0011);
    tbl[13] = mk(0, 4'hF, 4'b0110, 4'h0,   -1, 2'b11, 4'b0111);
    tbl[14] = mk(0, 4'hF, 4'b0011, 4'h0,  500, 2'b01, 4'b0000);
    tbl[15] = mk(0, 4'hE, 4'b0001, 4'h0,   -1, 2'b01, 4'b0000);
    tbl[16] = mk(0, 4'hF, 4'b0000, 4'h4,   -1, 2'b01, 4'b0100);
    tbl[17] = mk(0, 4'hF, 4'b0000, 4'h4,   -1, 2'b01, 4'b0100);
    tbl[18] = mk(0, 4'hF, 4'b1111, 4'h0, 1023, 2'b10, 4'b0000);
    tbl[19] = mk(0, 4'hF, 4'b0000, 4'h0, 1023, 2'b01, 4'b0000);
    tbl[20] = mk(1, 4'hE, 4'b0001, 4'h0,   -1, 2'b01, 4'b0000);
    tbl[21] = mk(0, 4'hE, 4'b0001, 4'h0,   -1, 2'b01, 4'b0000);
    tbl[22] = mk(0, 4'hF, 4'b0101, 4'h0,   -1, 2'b10, 4'b0101);

    prev = 2'b00;
    for (int r = 0; r < 23; r++) begin
      if (tbl[r].rst) begin
        do_reset();
        prev = 2'b00;
      end
      for (int k = 0; k < 1024; k++) begin
        e = tbl[r].hold | ((k >= 100 && k < 103) ? tbl[r].pulse : 4'h0);
        if (k == 1023) begin
          x.st = tbl[r].exp_state; x.fl = tbl[r].exp_flags; x.idx = r;
          sb_q.push_back(x);
        end
        cyc(e, tbl[r].mask, (k == tbl[r].clr_at));
        if (k == 1022) begin
          mid = (prev == 2'b11 && tbl[r].clr_at >= 0 && tbl[r].clr_at < 1023) ? 2'b01 : prev;
          chk("mid_state", r, {2'b00, state}, {2'b00, mid});
        end
      end
      while (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk("win_state", x.idx, {2'b00, state}, {2'b00, x.st});
        chk("win_flags", x.idx, fail_flags, x.fl);
        chk("win_warn", x.idx, {3'b000, warn}, {3'b000, (x.st == 2'b10)});
        chk("win_alarm", x.idx, {3'b000, alarm}, {3'b000, (x.st == 2'b11)});
      end
      prev = tbl[r].exp_state;
    end

    // Mid-window asynchronous reset while in WARN
    for (int k = 0; k < 300; k++) cyc(4'h0, 4'hF, 1'b0);
    chk("pre_rst_warn", 100, {3'b000, warn}, 4'h1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_state", 100, {2'b00, state}, 4'h0);
    chk("async_warn", 100, {3'b000, warn}, 4'h0);
    chk("async_alarm", 100, {3'b000, alarm}, 4'h0);
    chk("async_flags", 100, fail_flags, 4'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Warmup restarts: exactly 1024 edges to MONITOR
    for (int k = 0; k < 1023; k++) cyc(4'h0, 4'hF, 1'b0);
    chk("warmup_1023", 101, {2'b00, state}, 4'h0);
    cyc(4'h0, 4'hF, 1'b0);
    chk("warmup_1024", 101, {2'b00, state}, 4'h1);
    chk("warmup_flags", 101, fail_flags, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
